if_id_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and selects the next PC from PC+4, branch target or jump target.
- Drives the instruction-memory address and latches the fetched word into ID_order for the decode stage.
- Consumes the load-use `hazard` stall from the hazard unit, EX branch resolution and ID jump resolution. Flushes or holds the IF/ID register as required.

---
 rtl/if_id_stage_pkg.sv | 12 +
 rtl/if_id_stage_if.sv | 25 ++
 rtl/if_id_stage_if_id_reg.sv | 42 ++++
 rtl/if_id_stage.sv | 56 +++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared constants and control encodings for the fetch stage
package if_id_stage_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {PC_SEQ, PC_HOLD, PC_BRANCH, PC_JUMP} pc_sel_e;
    typedef enum logic [1:0] {LOAD, HOLD, FLUSH} ifid_act_e;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_id_stage_if.sv
// if_id_stage_if: control, instruction-memory and IF/ID signals of the fetch stage
interface if_id_stage_if #(parameter int CNT_W = 16);
    logic              hazard;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic              jump;
    logic [31:0]       jump_target;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic [31:0]       IF_pc;
    logic [31:0]       ID_order;
    logic [31:0]       ID_pc4;
    logic              ID_valid;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output hazard, branch_taken, branch_target, jump, jump_target, imem_rdata, imem_ready,
        input  imem_addr, IF_pc, ID_order, ID_pc4, ID_valid, stall_cnt
    );
    modport slave (
        input  hazard, branch_taken, branch_target, jump, jump_target, imem_rdata, imem_ready,
        output imem_addr, IF_pc, ID_order, ID_pc4, ID_valid, stall_cnt
    );
endinterface

// File: rtl/if_id_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and flush-to-bubble controls
module if_id_reg
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = if_id_stage_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ifid_act_e   act_i,
    input  logic [31:0] order_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] order_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);
    logic [31:0] order_q, order_d, pc4_q, pc4_d;
    logic        valid_q, valid_d;

    // next contents: new word on load, bubble on flush, unchanged on hold
    always_comb begin
        order_d = act_i == LOAD ? order_i : act_i == FLUSH ? NOP_WORD : order_q;
        pc4_d   = act_i == LOAD ? pc4_i   : act_i == FLUSH ? 32'd0    : pc4_q;
        valid_d = act_i == LOAD ? 1'b1    : act_i == FLUSH ? 1'b0     : valid_q;
    end

    // register update, reset leaves a bubble in ID
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            order_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            order_q <= order_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign order_o = order_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC register, next-PC priority select, stall counter and IF/ID register
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = if_id_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_WORD = if_id_stage_pkg::NOP_WORD,
    parameter int          CNT_W    = 16
) (
    input logic           clk,
    input logic           rst_n,
    if_id_stage_if.slave  bus
);
    logic [31:0]      pc_q, pc_d, pc4;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    pc_sel_e          pc_sel;
    ifid_act_e        act;

    // priority: EX branch, load-use stall, ID jump, imem wait state, sequential fetch
    always_comb begin
        pc4    = pc_q + 32'd4;
        pc_sel = bus.branch_taken ? PC_BRANCH : bus.hazard ? PC_HOLD : bus.jump ? PC_JUMP :
                 !bus.imem_ready ? PC_HOLD : PC_SEQ;
        act    = bus.branch_taken ? FLUSH : bus.hazard ? HOLD : bus.jump ? FLUSH :
                 !bus.imem_ready ? FLUSH : LOAD;
        pc_d   = pc_sel == PC_BRANCH ? align_word(bus.branch_target) :
                 pc_sel == PC_JUMP   ? align_word(bus.jump_target) :
                 pc_sel == PC_SEQ    ? pc4 : pc_q;
        stall_cnt_d = bus.hazard && !(&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    // fetch PC and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .act_i   (act),
        .order_i (bus.imem_rdata),
        .pc4_i   (pc4),
        .order_o (bus.ID_order),
        .pc4_o   (bus.ID_pc4),
        .valid_o (bus.ID_valid)
    );

    assign bus.imem_addr = pc_q;
    assign bus.IF_pc     = pc_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule
